// File: rtl/aurora_tx_arbiter.sv
// Round-robin packet arbiter sharing one Aurora TX AXI-Stream port between two requesters.
// Define ARB_PKT_HEADER_EN to prepend a one-beat owner header to every granted packet.
module aurora_tx_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  peripheral_reset,
  input  logic                  channel_up,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tvalid,
  input  logic                  s0_tlast,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tvalid,
  input  logic                  s1_tlast,
  output logic                  s1_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef ARB_PKT_HEADER_EN
  localparam logic [1:0] ST_HDR  = 2'd1;
`endif
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;
`ifdef ARB_PKT_HEADER_EN
  localparam logic [1:0] ST_GRANT = ST_HDR;
`else
  localparam logic [1:0] ST_GRANT = ST_XFER;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_r, state_s;
  logic                  owner_r, owner_s;
  logic                  last_served_r, last_served_s;
  logic [CNT_WIDTH-1:0]  pkt_count_r, drop_count_r;
  logic                  pkt_inc_s, drop_inc_s;
  logic [DATA_WIDTH-1:0] own_data_s;
  logic                  own_valid_s, own_last_s;

  // Saturating increment: counters stick at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      sat_inc = v + CNT_ONE;
    end else begin
      sat_inc = v;
    end
  endfunction

  // Select the current owner's stream.
  always_comb begin
    own_data_s  = s0_tdata;
    own_valid_s = s0_tvalid;
    own_last_s  = s0_tlast;
    if (owner_r) begin
      own_data_s  = s1_tdata;
      own_valid_s = s1_tvalid;
      own_last_s  = s1_tlast;
    end else begin
      own_data_s  = s0_tdata;
      own_valid_s = s0_tvalid;
      own_last_s  = s0_tlast;
    end
  end

  // Next-state, arbitration and packet-completion decode.
  always_comb begin
    state_s       = state_r;
    owner_s       = owner_r;
    last_served_s = last_served_r;
    pkt_inc_s     = 1'b0;
    drop_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (channel_up && (s0_tvalid || s1_tvalid)) begin
          if (s0_tvalid && s1_tvalid) begin
            owner_s = ~last_served_r;
          end else begin
            owner_s = s1_tvalid;
          end
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
`ifdef ARB_PKT_HEADER_EN
      ST_HDR: begin
        if (!channel_up) begin
          state_s = ST_DROP;
        end else if (m_tready) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_HDR;
        end
      end
`endif
      ST_XFER: begin
        if (!channel_up) begin
          state_s = ST_DROP;
        end else if (own_valid_s && m_tready && own_last_s) begin
          pkt_inc_s     = 1'b1;
          last_served_s = owner_r;
          state_s       = ST_IDLE;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_DROP: begin
        // Once draining, finish the packet even if the lane recovers.
        if (own_valid_s && own_last_s) begin
          drop_inc_s    = 1'b1;
          last_served_s = owner_r;
          state_s       = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, owner history and status counters.
  always_ff @(posedge clk) begin
    if (peripheral_reset) begin
      state_r       <= ST_IDLE;
      owner_r       <= 1'b0;
      last_served_r <= 1'b1;
      pkt_count_r   <= {CNT_WIDTH{1'b0}};
      drop_count_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r       <= state_s;
      owner_r       <= owner_s;
      last_served_r <= last_served_s;
      pkt_count_r   <= sat_inc(pkt_count_r, pkt_inc_s);
      drop_count_r  <= sat_inc(drop_count_r, drop_inc_s);
    end
  end

  // Stream mux and handshake steering; m_tvalid is gated by channel_up in the same cycle.
  always_comb begin
    m_tdata   = {DATA_WIDTH{1'b0}};
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    grant     = 2'b00;
    if (peripheral_reset) begin
      grant = 2'b00;
    end else begin
      case (state_r)
`ifdef ARB_PKT_HEADER_EN
        ST_HDR: begin
          m_tdata  = {{(DATA_WIDTH-1){1'b0}}, owner_r};
          m_tvalid = channel_up;
          grant    = owner_r ? 2'b10 : 2'b01;
        end
`endif
        ST_XFER: begin
          m_tdata   = own_data_s;
          m_tvalid  = own_valid_s & channel_up;
          m_tlast   = own_last_s;
          s0_tready = ~owner_r & m_tready & channel_up;
          s1_tready = owner_r & m_tready & channel_up;
          grant     = owner_r ? 2'b10 : 2'b01;
        end
        ST_DROP: begin
          s0_tready = ~owner_r;
          s1_tready = owner_r;
          grant     = owner_r ? 2'b10 : 2'b01;
        end
        default: begin
          grant = 2'b00;
        end
      endcase
    end
  end

  assign pkt_count  = pkt_count_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Self-checking bench for aurora_tx_arbiter: directed scenarios plus a randomized phase
// scored against a packet-level model (per-source beat queues, drop legality, saturating totals).
module tb_aurora_tx_arbiter;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
`ifdef ARB_PKT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          peripheral_reset, channel_up;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_count, drop_count;

  aurora_tx_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .peripheral_reset(peripheral_reset), .channel_up(channel_up),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t drv0[$], drv1[$], exp0[$], exp1[$];
  int    order[$], first_cyc[$], tlast_cyc[$], beats_q[$];
  int    cyc = 0, exp_pkts = 0, exp_drops = 0, n_issued = 0;
  int    pkt_start_cyc = 0, pay_beats = 0, pkt_mbeats = 0;
  int    rdy_mode = 0, gap_pct = 0;
  bit    cur_down = 1'b0, hdr_done = 1'b1;
  logic  [1:0] prev_grant = 2'b00, g_smp = 2'b00;
  logic  hm_smp = 1'b0, mv_smp = 1'b0, h0_smp = 1'b0, h1_smp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [CW-1:0] sat(input int n);
    if (n >= int'(CMAX)) return CMAX;
    else return n[CW-1:0];
  endfunction

  task automatic present();
    if (!s0_tvalid && drv0.size() > 0) begin
      s0_tvalid = 1'b1; s0_tdata = drv0[0].d; s0_tlast = drv0[0].l;
    end
    if (!s1_tvalid && drv1.size() > 0) begin
      s1_tvalid = 1'b1; s1_tdata = drv1[0].d; s1_tlast = drv1[0].l;
    end
  endtask

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.l = (i == len - 1);
      if (src == 1) begin drv1.push_back(b); exp1.push_back(b); end
      else begin drv0.push_back(b); exp0.push_back(b); end
    end
    n_issued++;
    present();
  endtask

  // One clock: sample and score at negedge, then update sources just after posedge.
  task automatic step();
    beat_t b;
    int    src;
    @(negedge clk);
    g_smp  = grant;
    mv_smp = m_tvalid;
    hm_smp = m_tvalid & m_tready;
    h0_smp = s0_tvalid & s0_tready;
    h1_smp = s1_tvalid & s1_tready;
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      pkt_start_cyc = cyc; hdr_done = (HDR == 0); pay_beats = 0; pkt_mbeats = 0;
    end
    if (grant != 2'b00 && !channel_up) cur_down = 1'b1;
    check("grant_onehot0", $onehot0(grant), 1'b1);
    if (grant == 2'b00) check("idle_ready", {s1_tready, s0_tready}, 2'b00);
    else if (grant == 2'b01) check("nonowner_ready1", s1_tready, 1'b0);
    else check("nonowner_ready0", s0_tready, 1'b0);
    if (!channel_up) check("mvalid_gated", m_tvalid, 1'b0);
    if (grant != 2'b00 && channel_up && !cur_down) begin
      if (!hdr_done) check("hdr_ready", {s1_tready, s0_tready}, 2'b00);
      else if (grant == 2'b01) check("s0_ready_mirror", s0_tready, m_tready);
      else check("s1_ready_mirror", s1_tready, m_tready);
    end
    src = grant[1] ? 1 : 0;
    if (hm_smp) begin
      pkt_mbeats++;
      if (!hdr_done) begin
        check("hdr_data", m_tdata, src);
        check("hdr_last", m_tlast, 1'b0);
        check("hdr_no_src_hs", h0_smp | h1_smp, 1'b0);
        hdr_done = 1'b1;
      end else begin
        check("exp_avail", (src == 1) ? (exp1.size() > 0) : (exp0.size() > 0), 1'b1);
        b = (src == 1) ? exp1.pop_front() : exp0.pop_front();
        check("passthru_hs", (src == 1) ? h1_smp : h0_smp, 1'b1);
        check("data", m_tdata, b.d);
        check("last", m_tlast, b.l);
        pay_beats++;
        if (b.l) begin
          exp_pkts++;
          order.push_back(src); first_cyc.push_back(pkt_start_cyc);
          tlast_cyc.push_back(cyc); beats_q.push_back(pkt_mbeats);
        end
      end
    end else if (h0_smp | h1_smp) begin
      src = h1_smp ? 1 : 0;
      check("discard_legal", cur_down, 1'b1);
      check("discard_avail", (src == 1) ? (exp1.size() > 0) : (exp0.size() > 0), 1'b1);
      b = (src == 1) ? exp1.pop_front() : exp0.pop_front();
      if (b.l) begin exp_drops++; cur_down = 1'b0; end
    end
    prev_grant = grant;
    @(posedge clk);
    #1;
    cyc++;
    if (h0_smp) begin void'(drv0.pop_front()); s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    if (h1_smp) begin void'(drv1.pop_front()); s1_tvalid = 1'b0; s1_tlast = 1'b0; end
    if ($urandom_range(99) >= gap_pct) present();
    case (rdy_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'($urandom_range(1));
      default: m_tready = 1'b1;
    endcase
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    step();
    while (n < max && !(drv0.size() == 0 && drv1.size() == 0 && g_smp == 2'b00)) begin
      step();
      n++;
    end
    checks++;
    assert (n < max) else begin
      errors++;
      $error("FAIL idle_timeout observed=%0d expected<%0d", n, max);
    end
  endtask

  task automatic do_reset();
    peripheral_reset = 1'b1;
    drv0.delete(); drv1.delete(); exp0.delete(); exp1.delete();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    exp_pkts = 0; exp_drops = 0; n_issued = 0; cur_down = 1'b0;
    step();
    check("rst_in_mvalid", mv_smp, 1'b0);
    check("rst_in_grant", g_smp, 2'b00);
    step();
    peripheral_reset = 1'b0;
    step();
    check("rst_grant", grant, 2'b00);
    check("rst_mvalid", m_tvalid, 1'b0);
    check("rst_mlast", m_tlast, 1'b0);
    check("rst_mdata", m_tdata, 64'd0);
    check("rst_ready", {s1_tready, s0_tready}, 2'b00);
    check("rst_pkt_count", pkt_count, 4'd0);
    check("rst_drop_count", drop_count, 4'd0);
  endtask

  initial begin
    peripheral_reset = 1'b1; channel_up = 1'b1; m_tready = 1'b1;
    s0_tdata = 64'd0; s1_tdata = 64'd0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    do_reset();

    // Single 4-beat packet on s0
    add_pkt(0, 4);
    step(); check("t1_grant_req_cycle", g_smp, 2'b00);
    step(); check("t1_grant", g_smp, 2'b01); check("t1_first_hs", hm_smp, 1'b1);
    run_until_idle(50);
    check("t1_pkt_count", pkt_count, 4'd1);
    check("t1_beats", beats_q[$], 4 + HDR);
    check("t1_src", order[$], 0);

    // Reset in the middle of a packet, then tie-break with both ports busy
    add_pkt(1, 6);
    repeat (3) step();
    do_reset();
    order.delete(); first_cyc.delete(); tlast_cyc.delete(); beats_q.delete();
    add_pkt(0, 2); add_pkt(1, 2); add_pkt(0, 2); add_pkt(1, 2);
    run_until_idle(100);
    check("t2_npkts", order.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_order%0d", i), order[i], i % 2);
    for (int i = 0; i < 3; i++) check($sformatf("t2_gap%0d", i), first_cyc[i+1] - tlast_cyc[i], 2);
    check("t2_pkt_count", pkt_count, 4'd4);

    // Channel down at idle blocks the grant
    channel_up = 1'b0;
    add_pkt(1, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_grant_down", g_smp, 2'b00);
      check("t3_s1_ready_down", s1_tready, 1'b0);
    end
    channel_up = 1'b1;
    run_until_idle(50);
    check("t3_src", order[$], 1);
    check("t3_beats", beats_q[$], 3 + HDR);
    check("t3_pkt_count", pkt_count, 4'd5);

    // Channel drops after beat 2 of an 8-beat s0 packet; s1 pending
    add_pkt(0, 8); add_pkt(1, 2);
    for (int i = 0; i < 50; i++) begin
      step();
      if (g_smp == 2'b01 && pay_beats == 2) break;
    end
    check("t4_reached_beat2", (g_smp == 2'b01 && pay_beats == 2), 1'b1);
    channel_up = 1'b0;
    step();
    check("t4_mvalid_drop", mv_smp, 1'b0);
    check("t4_grant_hold", g_smp, 2'b01);
    channel_up = 1'b1;
    run_until_idle(100);
    check("t4_drop_count", drop_count, 4'd1);
    check("t4_pkt_count", pkt_count, 4'd6);
    check("t4_npkts", order.size(), 6);
    check("t4_next_src", order[$], 1);

    // Backpressure: m_tready toggles every cycle
    m_tready = 1'b1; rdy_mode = 1;
    add_pkt(0, 4);
    run_until_idle(50);
    check("t5_cycles", tlast_cyc[$] - first_cyc[$] + 1, 8 + 2 * HDR);
    check("t5_beats", beats_q[$], 4 + HDR);
    check("t5_pkt_count", pkt_count, 4'd7);
    rdy_mode = 0; m_tready = 1'b1;

    // Repeated drops drive drop_count into saturation
    for (int k = 0; k < 16; k++) begin
      add_pkt(0, 3);
      for (int i = 0; i < 10; i++) begin
        step();
        if (g_smp != 2'b00) break;
      end
      channel_up = 1'b0;
      step();
      channel_up = 1'b1;
      run_until_idle(50);
    end
    check("t6_drop_sat", drop_count, CMAX);
    check("t6_pkt_hold", pkt_count, 4'd7);

    // Randomized traffic, gaps, backpressure and lane flaps
    rdy_mode = 2; gap_pct = 30;
    for (int k = 0; k < 40; k++) begin
      add_pkt(int'($urandom_range(1)), int'($urandom_range(5, 1)));
      repeat ($urandom_range(6)) begin
        channel_up = ($urandom_range(15) != 0);
        step();
      end
    end
    channel_up = 1'b1; rdy_mode = 0; gap_pct = 0; m_tready = 1'b1;
    run_until_idle(3000);
    check("t7_pkt_count", pkt_count, sat(exp_pkts));
    check("t7_drop_count", drop_count, sat(exp_drops));
    check("t7_exp0_empty", exp0.size(), 0);
    check("t7_exp1_empty", exp1.size(), 0);
    check("t7_accounted", exp_pkts + exp_drops, n_issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
